// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and defaults for the CCSS core memory arbiter family.
package ccss_arb_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping modulo N. Shared with the bus arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);
  // scan N positions starting at ptr, keep the first hit
  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[IW'(j)]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_CORES cores.
// Optional build macro ARB_PERF_EN adds per-core 16-bit saturating grant counters.
module core_mem_arbiter
  import ccss_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
`ifdef ARB_PERF_EN
  ,
  output logic [NUM_CORES*CNT_W-1:0]  grant_cnt
`endif
);
  localparam int IW = $clog2(NUM_CORES);

  arb_state_e          state, state_n;
  logic [IW-1:0]       rr_ptr, win_idx, lat_idx;
  logic                win_found, lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata, rdata_q;

  rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // grant capture, pointer advance and read-data hold register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        lat_idx   <= win_idx;
        lat_we    <= we[win_idx];
        lat_addr  <= addr[win_idx*ADDR_W +: ADDR_W];
        lat_wdata <= wdata[win_idx*DATA_W +: DATA_W];
        rr_ptr    <= (win_idx == IW'(NUM_CORES-1)) ? '0 : win_idx + IW'(1);
      end
      if (state == RESP) rdata_q <= mem_rdata;
    end
  end

  // next state, strobes and acknowledge; rdata passes memory data through
  // during RESP so it is valid in the ack cycle, then holds the captured copy
  always_comb begin
    state_n = state;
    ack     = '0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    rdata   = rdata_q;
    case (state)
      IDLE:   if (win_found) state_n = ACCESS;
      ACCESS: begin
        if (lat_we) begin
          mem_we       = 1'b1;
          ack[lat_idx] = 1'b1;
          state_n      = IDLE;
        end else begin
          mem_re  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        ack[lat_idx] = 1'b1;
        rdata        = mem_rdata;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);

`ifdef ARB_PERF_EN
  logic [NUM_CORES-1:0][CNT_W-1:0] cnt;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_cnt
    // per-core saturating grant counter
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                   cnt[i] <= '0;
      else if (ack[i] && ~&cnt[i]) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end
  assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_core_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_we, mem_re, busy;
`ifdef ARB_PERF_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  int m_ptr   = 0;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_a  = '0;
  logic [DW-1:0] pl_d  = '0;

  core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // synchronous single-port memory, one-cycle read latency
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; we = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (ack !== '0)      begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    vectors++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {mem_we, mem_re}); end
    vectors++; if (rdata !== '0)    begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    vectors++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    preload(8'h10, 16'h00AB);
    do_reset();
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 16'h0010;
    @(negedge clk);
    vectors++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_strobe got re=%b we=%b want re=1 we=0", mem_re, mem_we); end
    vectors++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr got %h want 0010", mem_addr); end
    vectors++; if (ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL rd_access got ack=%b busy=%b want 0000/1", ack, busy); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0100) begin errors++; $display("FAIL rd_ack got %b want 0100", ack); end
    vectors++; if (rdata !== 16'h00AB) begin errors++; $display("FAIL rd_data got %h want 00ab", rdata); end
    req[2] = 1'b0;
    @(negedge clk);
    vectors++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rd_after got ack=%b busy=%b want 0000/0", ack, busy); end
    vectors++; if (rdata !== 16'h00AB) begin errors++; $display("FAIL rd_hold got %h want 00ab", rdata); end
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1*AW +: AW] = 16'h0005; wdata[1*DW +: DW] = 16'h1234;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL wr_strobe got we=%b re=%b want we=1 re=0", mem_we, mem_re); end
    vectors++; if (mem_addr !== 16'h0005 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL wr_bus got %h/%h want 0005/1234", mem_addr, mem_wdata); end
    vectors++; if (ack !== 4'b0010) begin errors++; $display("FAIL wr_ack got %b want 0010", ack); end
    req[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (ack !== 4'b0010 || rdata !== 16'h1234) begin errors++; $display("FAIL wr_readback got ack=%b data=%h want 0010/1234", ack, rdata); end
    req[1] = 1'b0;
    ref_mem[5] = 16'h1234;
  endtask

  task automatic test_mid_change();
    preload(8'h20, 16'h5A5A);
    preload(8'h30, 16'h0F0F);
    do_reset();
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b0; addr[3*AW +: AW] = 16'h0020;
    @(negedge clk);
    vectors++; if (mem_addr !== 16'h0020 || mem_re !== 1'b1) begin errors++; $display("FAIL mid_addr got %h re=%b want 0020 re=1", mem_addr, mem_re); end
    req[3] = 1'b0; addr[3*AW +: AW] = 16'h0030; we[3] = 1'b1;
    @(negedge clk);
    vectors++; if (ack !== 4'b1000 || rdata !== 16'h5A5A) begin errors++; $display("FAIL mid_ack got ack=%b data=%h want 1000/5a5a", ack, rdata); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mid_idle got busy=%b we=%b want 0/0", busy, mem_we); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (ack !== 4'b0100) begin errors++; $display("FAIL rst_pre got %b want 0100", ack); end
    reset = 1'b1;
    #1;
    vectors++; if (ack !== '0 || mem_re !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_abort got ack=%b re=%b we=%b busy=%b want all 0", ack, mem_re, mem_we, busy); end
    @(negedge clk);
    reset = 1'b0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1; we[i] = 1'b0; addr[i*AW +: AW] = AW'(16'h0040 + i);
    end
    @(negedge clk);
    vectors++; if (mem_re !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL rst_regrant got re=%b addr=%h want 1/0040", mem_re, mem_addr); end
    req = '0;
    @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin errors++; $display("FAIL rst_ack got %b want 0001", ack); end
    @(negedge clk);
  endtask

  // Cycle loop: checks outputs at the negedge, updates core behaviour, then
  // predicts what the arbiter does at the following posedge.
  task automatic run_traffic(input int ncyc, input bit all_rd, output int order[$]);
    int ack_at[N];
    bit pend_rd[N], granted[N];
    logic [DW-1:0] exp_data[N];
    int idle_cnt[N];
    int free_cyc, w;
    logic [N-1:0] exp_ack;
    order = {};
    free_cyc = 0;
    for (int i = 0; i < N; i++) begin
      ack_at[i] = -1; pend_rd[i] = 0; granted[i] = 0; idle_cnt[i] = 0; exp_data[i] = '0;
    end
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      exp_ack = '0;
      for (int i = 0; i < N; i++) if (ack_at[i] == t) exp_ack[i] = 1'b1;
      vectors++; if (ack !== exp_ack) begin errors++; $display("FAIL trf_ack t=%0d got %b want %b", t, ack, exp_ack); end
      vectors++; if (busy !== (t < free_cyc)) begin errors++; $display("FAIL trf_busy t=%0d got %b want %b", t, busy, (t < free_cyc)); end
      vectors++; if ((mem_we & mem_re) !== 1'b0) begin errors++; $display("FAIL trf_strobes t=%0d got we=%b re=%b want not both", t, mem_we, mem_re); end
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) begin
          order.push_back(i);
          if (pend_rd[i]) begin
            vectors++; if (rdata !== exp_data[i]) begin errors++; $display("FAIL trf_rdata t=%0d core=%0d got %h want %h", t, i, rdata, exp_data[i]); end
          end
          req[i] = 1'b0; ack_at[i] = -1; granted[i] = 0; pend_rd[i] = 0;
          idle_cnt[i] = all_rd ? 0 : int'($urandom_range(0, 3));
        end else if (granted[i]) begin
          addr[i*AW +: AW] = AW'($urandom_range(0, 15));
          wdata[i*DW +: DW] = DW'($urandom);
          we[i] = all_rd ? 1'b0 : 1'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if (!req[i] && t < ncyc - 16) begin
          if (idle_cnt[i] == 0) begin
            req[i] = 1'b1;
            we[i] = all_rd ? 1'b0 : 1'($urandom);
            addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            wdata[i*DW +: DW] = DW'($urandom);
          end else idle_cnt[i]--;
        end
      end
      if (t >= free_cyc && |req) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_ptr = (w + 1) % N;
        granted[w] = 1;
        if (we[w]) begin
          ack_at[w] = t + 1;
          ref_mem[addr[w*AW +: 8]] = wdata[w*DW +: DW];
          free_cyc = t + 2;
        end else begin
          ack_at[w] = t + 2;
          pend_rd[w] = 1;
          exp_data[w] = ref_mem[addr[w*AW +: 8]];
          free_cyc = t + 3;
        end
      end
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int order[$];
    int exp_ord[6];
    exp_ord = '{0, 1, 2, 3, 0, 1};
    do_reset();
    run_traffic(40, 1'b1, order);
    vectors++; if (order.size() < 6) begin errors++; $display("FAIL fair_count got %0d want >=6", order.size()); end
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      vectors++; if (order[k] != exp_ord[k]) begin errors++; $display("FAIL fair_order idx=%0d got %0d want %0d", k, order[k], exp_ord[k]); end
    end
    for (int k = 0; k + 3 < order.size(); k++) begin
      vectors++;
      if (order[k] == order[k+1] || order[k] == order[k+2] || order[k] == order[k+3] ||
          order[k+1] == order[k+2] || order[k+1] == order[k+3] || order[k+2] == order[k+3]) begin
        errors++; $display("FAIL fair_window idx=%0d got %0d%0d%0d%0d want all distinct", k, order[k], order[k+1], order[k+2], order[k+3]);
      end
    end
  endtask

  task automatic test_random();
    int order[$];
    for (int a = 0; a < 16; a++) preload(8'(a), DW'($urandom));
    do_reset();
    run_traffic(2000, 1'b0, order);
    vectors++; if (order.size() < 100) begin errors++; $display("FAIL rand_volume got %0d acks want >=100", order.size()); end
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    int n;
    do_reset();
    n = 0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = 16'h0001; wdata[0 +: DW] = 16'h0000;
    for (int c = 0; c < 150000 && n < 70000; c++) begin
      @(negedge clk);
      if (ack[0]) n++;
    end
    req = '0;
    @(negedge clk);
    vectors++; if (n != 70000) begin errors++; $display("FAIL perf_acks got %0d want 70000", n); end
    vectors++; if (grant_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL perf_sat got %h want ffff", grant_cnt[15:0]); end
    vectors++; if (grant_cnt[N*16-1:16] !== '0) begin errors++; $display("FAIL perf_others got %h want 0", grant_cnt[N*16-1:16]); end
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_mid_change();
    test_reset_mid();
    test_fairness();
    test_random();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between NUM_CORES processor cores of the CCSS multi-core build.
- Sits between each core's memory-access control signals and the shared memory instance.
- Serialises requests, captures address/data at grant, sequences the one-cycle memory read latency and returns data with a per-core acknowledge pulse.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 16, memory address width
DATA_W, 16, memory data width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_CORES  per-core access request, level, held until ack
we  input  NUM_CORES  per-core write select (1=write, 0=read), valid with req
addr  input  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_CORES*DATA_W  per-core write data, same packing
ack  output  NUM_CORES  one-hot single-cycle completion pulse
rdata  output  DATA_W  read data, valid when ack[i] of a read
mem_addr  output  ADDR_W  address to shared memory
mem_wdata  output  DATA_W  write data to shared memory
mem_we  output  1  memory write enable
mem_re  output  1  memory read enable
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_re
busy  output  1  high when state != IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is set, select the first requester found scanning from rr_ptr upward, wrapping modulo NUM_CORES.
  - Latch the winner index, its we, addr and wdata into internal registers, then go to ACCESS.
  - Set rr_ptr = winner+1 (wraps to 0 after NUM_CORES-1).
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr and mem_wdata from the latched values.
  - Latched write: mem_we=1, and ack[winner]=1 in this same cycle.
    - Go to IDLE, or directly re-arbitrate? No: go to IDLE.
  - Latched read: mem_re=1, then go to RESP.
- RESP (1 cycle):
  - rdata <= mem_rdata (registered).
  - ack[winner]=1 in the cycle rdata becomes valid; go to IDLE.
- Latency from req sampled in IDLE: write acked 1 cycle later; read acked 2 cycles later with rdata valid.
- mem_we and mem_re are never high simultaneously.
- At most one ack bit is high per cycle.
- The core must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Changes to a core's addr/wdata/we after its grant do not affect the transaction in flight.
- req deasserted mid-transaction: the transaction still completes and ack is still issued.
- Simultaneous requests: exactly one winner per IDLE cycle; the others wait. Worst-case wait is (NUM_CORES-1) transactions.
- rdata holds its last read value until the next read completes.
- Async reset mid-transaction aborts immediately: no ack, all memory strobes low next edge.

Optional Feature:
ARB_PERF_EN
- Defined: adds output grant_cnt (NUM_CORES*16 bits), one 16-bit saturating counter per core.
  - Increments on each ack to that core; holds at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counters absent, no logic generated.

Decomposition:
- Package ccss_arb_pkg holds:
  - state encoding typedef (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - default width constants (ADDR_W=16, DATA_W=16).
- One sub-module: rr_pick.
  - Combinational round-robin priority selector.
  - Inputs: req vector and rr_ptr. Outputs: winner index and a found flag.
  - Reused by later bus arbiters.

Test Plan:
1. Single read: core 2 req=1 we=0 addr=16'h0010, memory holds 16'h00AB.
   - Required: mem_re high 1 cycle after req; ack[2] plus rdata=16'h00AB 2 cycles after req.
2. Single write: core 1 we=1 addr=16'h0005 wdata=16'h1234.
   - Required: mem_we=1, mem_addr=5, mem_wdata=16'h1234, ack[1] in the same cycle.
   - Later read of 5 returns 16'h1234.
3. Fairness: all 4 cores hold read requests continuously, reasserting after each ack.
   - Required: ack order 0,1,2,3,0,1.
   - No core acked twice before all others have been acked once.
4. Mid-transaction changes: core 3 drops req and changes addr in the ACCESS cycle.
   - Required: the original address is used and ack[3] is still issued.
5. Reset: assert reset during RESP.
   - Required: ack=0, mem_re=0, busy=0 immediately.
   - Next grant after release goes to core 0 (rr_ptr=0).
6. ARB_PERF_EN: 70000 writes from core 0.
   - Required: grant_cnt[15:0] saturates at 16'hFFFF; other counters stay 0.
